fprti_issue_ctrl: RTL



---
 rtl/fprti_issue_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fprti_issue_ctrl.sv
// Issue controller for the plane/ray intersection accelerator: collects operands,
// launches one computation per start and returns the result. Optional macro: FPRTI_TIMEOUT_EN.
module fprti_issue_ctrl #(
    parameter int                        NUM_FPRTI_REGS = 16,
    parameter logic [NUM_FPRTI_REGS-1:0] REQ_MASK       = 16'h7FFF,
    parameter int                        TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_valid_i,
    output logic                                wr_ready_o,
    input  logic [$clog2(NUM_FPRTI_REGS)-1:0]   wr_addr_i,
    input  logic [31:0]                         wr_data_i,
    input  logic                                start_valid_i,
    output logic                                start_ready_o,
    output logic                                result_valid_o,
    input  logic                                result_ready_i,
    output logic [31:0]                         result_data_o,
    output logic                                result_err_o,
    output logic                                busy_o,
    output logic [NUM_FPRTI_REGS-1:0][31:0]     fprti_regs_o,
    output logic                                input_valid_o,
    input  logic [31:0]                         return_i,
    input  logic                                output_valid_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                    state;
    logic [NUM_FPRTI_REGS-1:0] written;
    logic [NUM_FPRTI_REGS-1:0] wr_onehot;
    logic                      wr_fire;
    logic                      start_fire;
    logic                      addr_ok;
    logic                      operands_ok;

    assign wr_ready_o    = (state == IDLE);
    assign start_ready_o = (state == IDLE);
    assign wr_fire       = wr_valid_i && (state == IDLE);
    assign start_fire    = start_valid_i && (state == IDLE);
    assign addr_ok       = (32'(wr_addr_i) < 32'(NUM_FPRTI_REGS));

    // A write landing in the same cycle as a start counts toward the legality check.
    always_comb begin
        wr_onehot = '0;
        if (wr_fire && addr_ok) begin
            wr_onehot[wr_addr_i] = 1'b1;
        end
    end

    assign operands_ok = (((written | wr_onehot) & REQ_MASK) == REQ_MASK);

`ifdef FPRTI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            written        <= '0;
            fprti_regs_o   <= '0;
            result_valid_o <= 1'b0;
            result_data_o  <= 32'h0;
            result_err_o   <= 1'b0;
            input_valid_o  <= 1'b0;
            busy_o         <= 1'b0;
`ifdef FPRTI_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            input_valid_o <= 1'b0;
            if (wr_fire && addr_ok) begin
                fprti_regs_o[wr_addr_i] <= wr_data_i;
            end
            written <= written | wr_onehot;

            case (state)
                IDLE: begin
                    if (start_fire) begin
                        busy_o <= 1'b1;
                        if (operands_ok) begin
                            state         <= ISSUE;
                            input_valid_o <= 1'b1;
                        end else begin
                            state          <= RESP;
                            result_valid_o <= 1'b1;
                            result_err_o   <= 1'b1;
                            result_data_o  <= 32'h0;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef FPRTI_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // A result on the terminal count still wins over the timeout.
                    if (output_valid_i) begin
                        state          <= RESP;
                        result_valid_o <= 1'b1;
                        result_err_o   <= 1'b0;
                        result_data_o  <= return_i;
                    end
`ifdef FPRTI_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state          <= RESP;
                        result_valid_o <= 1'b1;
                        result_err_o   <= 1'b1;
                        result_data_o  <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (result_ready_i) begin
                        state          <= IDLE;
                        result_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
